// File: rtl/keypad_emulator.sv
// Keypad matrix emulator: plays one press/release of a hex key into a
// row/column scanner. Each press has a contact-bounce phase, then a clean
// hold phase, then a release-bounce phase. Bounce is driven by an 8-bit LFSR.
// The row lines follow the live column drive combinationally, as a real
// pulled-up keypad matrix would.
module keypad_emulator #(
  parameter int          BOUNCE_CYCLES = 64,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  col_n,
  input  logic        press_req,
  input  logic [3:0]  key_code,
  input  logic [15:0] hold_cycles,
  output logic [3:0]  row_n,
  output logic        busy,
  output logic        done
);

  // The counter holds up to the longest phase, so it never wraps.
  localparam int CNT_W = $clog2(65535 + BOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] BOUNCE_LAST =
    CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_PRESS_BOUNCE = 2'd1;
  localparam logic [1:0] S_HELD         = 2'd2;
  localparam logic [1:0] S_REL_BOUNCE   = 2'd3;

  logic [1:0]       state_reg,   state_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic [15:0]      hold_reg,    hold_next;
  logic [1:0]       row_idx_reg, row_idx_next;
  logic [1:0]       col_idx_reg, col_idx_next;
  logic [7:0]       lfsr_reg,    lfsr_next;
  logic             contact_reg, contact_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;

  logic [CNT_W-1:0] hold_last;
  logic             in_bounce;
  logic             lfsr_fb;
  logic             col_hit;

  // Key position in the matrix, packed as {row, col}.
  function automatic logic [3:0] decode_key(input logic [3:0] code);
    logic [3:0] rc;
    case (code)
      4'h1:    rc = {2'd0, 2'd0};
      4'h2:    rc = {2'd0, 2'd1};
      4'h3:    rc = {2'd0, 2'd2};
      4'hA:    rc = {2'd0, 2'd3};
      4'h4:    rc = {2'd1, 2'd0};
      4'h5:    rc = {2'd1, 2'd1};
      4'h6:    rc = {2'd1, 2'd2};
      4'hB:    rc = {2'd1, 2'd3};
      4'h7:    rc = {2'd2, 2'd0};
      4'h8:    rc = {2'd2, 2'd1};
      4'h9:    rc = {2'd2, 2'd2};
      4'hC:    rc = {2'd2, 2'd3};
      4'hE:    rc = {2'd3, 2'd0};
      4'h0:    rc = {2'd3, 2'd1};
      4'hF:    rc = {2'd3, 2'd2};
      default: rc = {2'd3, 2'd3};  // 4'hD
    endcase
    return rc;
  endfunction

  // A hold of zero still gives one clean held cycle.
  assign hold_last = (hold_reg == 16'd0) ? '0 : CNT_W'(hold_reg - 16'd1);
  assign in_bounce = (state_reg == S_PRESS_BOUNCE) || (state_reg == S_REL_BOUNCE);
  // Fibonacci feedback for x^8 + x^6 + x^5 + x^4 + 1.
  assign lfsr_fb   = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

  // Sequence FSM: phase transitions, phase counter and request latching.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hold_next    = hold_reg;
    row_idx_next = row_idx_reg;
    col_idx_next = col_idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (press_req) begin
          hold_next                    = hold_cycles;
          {row_idx_next, col_idx_next} = decode_key(key_code);
          cnt_next                     = '0;
          state_next = (BOUNCE_CYCLES == 0) ? S_HELD : S_PRESS_BOUNCE;
        end
      end
      S_PRESS_BOUNCE: begin
        if (cnt_reg == BOUNCE_LAST) begin
          cnt_next   = '0;
          state_next = S_HELD;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (cnt_reg == hold_last) begin
          cnt_next   = '0;
          state_next = (BOUNCE_CYCLES == 0) ? S_IDLE : S_REL_BOUNCE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_REL_BOUNCE: begin
        if (cnt_reg == BOUNCE_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Contact, LFSR and status flags for the cycle that state_next describes.
  // The LFSR advances once per bounce cycle, so during a bounce cycle the
  // registered contact equals the current LFSR bit 0.
  always_comb begin
    lfsr_next = in_bounce ? {lfsr_reg[6:0], lfsr_fb} : lfsr_reg;
    case (state_next)
      S_PRESS_BOUNCE,
      S_REL_BOUNCE: contact_next = lfsr_next[0];
      S_HELD:       contact_next = 1'b1;
      default:      contact_next = 1'b0;
    endcase
    busy_next = (state_next != S_IDLE);
    done_next = (state_reg != S_IDLE) && (state_next == S_IDLE);
  end

  // State registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      row_idx_reg <= '0;
      col_idx_reg <= '0;
      lfsr_reg    <= LFSR_SEED;
      contact_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
      row_idx_reg <= row_idx_next;
      col_idx_reg <= col_idx_next;
      lfsr_reg    <= lfsr_next;
      contact_reg <= contact_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // The latched column is being driven low by the scanner right now.
  assign col_hit = ~col_n[col_idx_reg];

  // Matrix model: only the latched row can be pulled low, and only while
  // the contact is closed and its column is selected.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      localparam logic [1:0] ROW_ID = 2'(gi);
      assign row_n[gi] = ~(contact_reg && col_hit && (row_idx_reg == ROW_ID));
    end
  endgenerate

  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_CYCLES, default 64: length in clk cycles of each contact-bounce phase; 0 disables bounce.
REQ-002 Parameter LFSR_SEED, default 8'hA5: reset value of the bounce LFSR; any nonzero value is legal.
REQ-003 Port clk  input  1  single clock; every flop is clocked on its rising edge.
REQ-004 Port nrst  input  1  reset, asynchronous and active-low.
REQ-005 Port col_n  input  4  column drive from the scanner, active-low; bit c low means column c is selected.
REQ-006 Port press_req  input  1  request to perform one full press/release of key_code.
REQ-007 Port key_code  input  4  hex value of the key to press; sampled only when a request is accepted.
REQ-008 Port hold_cycles  input  16  number of clean held cycles; sampled only when a request is accepted.
REQ-009 Port row_n  output  4  row lines to the scanner, active-low, modelling the pulled-up keypad matrix.
REQ-010 Port busy  output  1  high while a press sequence is in progress.
REQ-011 Port done  output  1  one-cycle pulse when a sequence completes.

Function
REQ-012 Key mapping (row r, col c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D; c is the position within the row, 0..3.
REQ-013 The code latched at accept is decoded once into a registered row index and col index.
REQ-014 The FSM states are IDLE, PRESS_BOUNCE, HELD, REL_BOUNCE.
REQ-015 In IDLE with press_req=1, the edge latches code and hold, clears the counter, and enters PRESS_BOUNCE; if BOUNCE_CYCLES=0 it enters HELD instead.
REQ-016 busy is registered and is 1 exactly when the state is not IDLE, so it rises in the cycle after accept.
REQ-017 press_req while busy=1 is ignored; the code and hold registers do not change.
REQ-018 PRESS_BOUNCE lasts exactly BOUNCE_CYCLES cycles with contact=lfsr[0], then the FSM enters HELD.
REQ-019 HELD lasts exactly max(hold,1) cycles with contact=1; hold_cycles=0 is treated as 1.
REQ-020 REL_BOUNCE lasts exactly BOUNCE_CYCLES cycles with contact=lfsr[0], then the FSM enters IDLE.
REQ-021 If BOUNCE_CYCLES=0, HELD goes directly to IDLE.
REQ-022 In IDLE, contact=0.
REQ-023 done is registered and equals 1 only in the first cycle back in IDLE after a sequence.
REQ-024 A request accepted in the same cycle that done=1 is legal, giving back-to-back sequences.
REQ-025 busy lasts 2*BOUNCE_CYCLES + max(hold,1) cycles.
REQ-026 The LFSR is 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
REQ-027 The LFSR shifts only in cycles spent in a bounce state and holds otherwise.
REQ-028 The LFSR is never reseeded except by reset, so the bounce pattern continues across sequences.
REQ-029 row_n is combinational from registered contact, row index, col index and the live col_n.
REQ-030 row_n[r] = 0 iff contact=1 and col_n[c]=0 for the latched (r,c); all other row bits are 1.
REQ-031 row_n has zero-cycle latency from col_n, like a real matrix.
REQ-032 If several col_n bits are low, the row is pulled low whenever the latched column is among them.
REQ-033 All counters are wide enough for 65535 + BOUNCE_CYCLES without wrap.

Reset
REQ-034 While nrst=0, state=IDLE, busy=0, done=0, contact=0, row_n=4'hF, LFSR=LFSR_SEED, and the counter, code and index registers are 0.
REQ-035 Reset asserted mid-sequence aborts the sequence immediately and asynchronously: row_n=4'hF at once, and no done pulse.
REQ-036 After nrst deasserts, the first edge may accept a request.

Verification
REQ-037 BOUNCE_CYCLES=0, key_code=5, hold=10, col_n cycling 1110/1101/1011/0111 -> row_n=1101 only while col_n=1101; busy for 10 cycles; done one cycle after.
REQ-038 Default BOUNCE_CYCLES, key_code=D, hold=100 -> row_n[3] toggles per the LFSR while col_n=0111 for 64 cycles, is steady 0 for 100 cycles, toggles 64 cycles, then stays 1; busy=228 cycles.
REQ-039 press_req with key_code=2 held high throughout a key_code=8 sequence -> only key 8 (r2,c1) appears; key 2 is accepted at the done cycle, starting a back-to-back sequence.
REQ-040 hold_cycles=0, BOUNCE_CYCLES=0 -> busy=1 cycle; row pulled low for exactly 1 cycle when the column is selected; done follows.
REQ-041 nrst pulsed low midway through HELD -> row_n=4'hF and busy=0 asynchronously, no done; the next request's bounce pattern starts from LFSR_SEED.
REQ-042 col_n=4'hF for a whole sequence -> row_n stays 4'hF; busy and done timing are unchanged.
